spi_initiator: RTL and testbench
================================

# spi_initiator

Host-side SPI initiator that drives the `cs`/`sclk`/`mosi` pins of the tape-in SPI minion and captures `miso`. It is the other end of the minion: it shifts out one `BIT_WIDTH`-bit packet per transaction and simultaneously shifts in the minion's reply. Packets are exchanged with latency-insensitive val/rdy streams. It is used in the FPGA test harness and as a bench driver for the minion-facing top level.

## Interface
- `BIT_WIDTH`, default 20: packet width in bits, must be ≥ 2.
- `CLK_DIV`, default 4: `clk` cycles per `sclk` half-period, must be ≥ 1.

- `clk` input 1: system clock; the only clock.
- `reset` input 1: asynchronous, active-high reset.
- `send_msg` input `BIT_WIDTH`: packet to transmit, MSB first.
- `send_val` input 1: `send_msg` is valid.
- `send_rdy` output 1: initiator is idle and accepts a packet.
- `recv_msg` output `BIT_WIDTH`: packet received on `miso`; bit N-1 is the first bit received.
- `recv_parity` output 1: XOR of all bits of `recv_msg`.
- `recv_val` output 1: `recv_msg`/`recv_parity` are valid.
- `recv_rdy` input 1: consumer accepts `recv_msg`.
- `cs` output 1: chip select, active low.
- `sclk` output 1: SPI clock, idle low.
- `mosi` output 1: data to minion.
- `miso` input 1: data from minion; assumed already synchronous to `clk`.

## Operation
- SPI mode 0:
  - Minion samples `mosi` on the `sclk` rise.
  - Minion changes `miso` after the `sclk` fall.
- All outputs are registered. Reset values:
  - `cs`=1, `sclk`=0, `mosi`=0
  - `recv_val`=0, `recv_msg`=0, `recv_parity`=0
  - `send_rdy`=1
- FSM states: IDLE, SETUP, HIGH, LOW, DONE.
- IDLE:
  - `send_rdy`=1.
  - On `send_val && send_rdy`: load the shift register, drive `mosi`=`send_msg[N-1]`, `cs`=0, go to SETUP.
- SETUP: hold for `CLK_DIV` cycles with `sclk`=0, then go to HIGH.
- HIGH:
  - On entry: `sclk`=1 and `miso` is shifted into the LSB of the receive register. The sampled value is the `miso` value in the last LOW/SETUP cycle.
  - Hold `CLK_DIV` cycles, then go to LOW.
- LOW:
  - On entry: `sclk`=0 and `mosi` advances to the next lower bit.
  - After `CLK_DIV` cycles: if all `BIT_WIDTH` bits have been sampled, go to DONE; otherwise go to HIGH.
  - In the final LOW phase (cs hold), `mosi` is 0.
- DONE:
  - On entry: `cs`=1, `recv_val`=1, `recv_parity` registered.
  - `recv_msg` is held stable until `recv_val && recv_rdy`, then go to IDLE.
- `send_rdy`=0 in every state except IDLE. `send_val` outside IDLE is ignored, not queued.
- Width rules:
  - Half-period counter is `$clog2(CLK_DIV+1)` bits and counts down from `CLK_DIV-1` to 0.
  - Bit counter is `$clog2(BIT_WIDTH+1)` bits.
  - Neither counter wraps mid-packet.
- Reset mid-transaction: all state clears immediately. `cs` rises and `sclk` falls asynchronously. No `recv_val` is produced for the aborted packet.

## Timing
- Send handshake at edge 0 → `cs` falls at edge 0 (registered with the accept).
- Bit k (k=0 is the MSB) rises `sclk` at edge `CLK_DIV*(1+2k)`.
- `cs` is low for exactly `CLK_DIV*(2*BIT_WIDTH+1)` cycles. `recv_val` rises on the same edge as `cs`.
- `sclk` has 50% duty; period is `2*CLK_DIV` cycles; exactly `BIT_WIDTH` rising edges per transaction.
- `mosi` is stable for ≥ `CLK_DIV` cycles before and after each `sclk` rise.
- Minimum `cs`-high gap between back-to-back transactions is 2 cycles: the DONE handshake cycle plus one IDLE cycle.

## Structure
- `spi_initiator_pkg`: state enum `spi_init_state_t` {IDLE, SETUP, HIGH, LOW, DONE}.
- Single module. The shift registers and counters are inline; no sub-module is warranted.

## Test plan
- Reset:
  - Assert `reset` with no clock edge → `cs`=1, `sclk`=0, `mosi`=0, `recv_val`=0, `send_rdy`=1.
- Basic transfer (`BIT_WIDTH`=20, `CLK_DIV`=2):
  - Send 0xA5A5A; minion model replies 0x3C3C3.
  - Expect `mosi` sampled at the 20 `sclk` rises = 0xA5A5A.
  - Expect `cs` low for 82 cycles.
  - Expect `recv_msg`=0x3C3C3 and `recv_parity`=0.
- Back-pressure:
  - Hold `recv_rdy`=0 for 10 cycles after `recv_val`.
  - Expect `recv_msg` stable, `send_rdy`=0, `cs`=1, `sclk`=0.
  - Expect a `send_val` pulse in that window to be dropped.
- Back-to-back:
  - Hold `send_val`=1 and `recv_rdy`=1 with 0x00001 then 0xFFFFE.
  - Expect two transactions separated by exactly 2 `cs`-high cycles.
  - Expect the echoed results to match.
- Reset mid-transfer:
  - Assert `reset` after the 7th `sclk` rise → `cs`=1 immediately, no `recv_val`.
  - Then send 0x00007 with echo → `recv_msg`=0x00007, `recv_parity`=1.
- `CLK_DIV`=1:
  - `sclk` period is 2 cycles and `cs` is low for 41 cycles.
  - Random 1000-packet echo test → zero mismatches.

Source files
------------

// File: rtl/spi_initiator_pkg.sv
// Shared types for the SPI initiator: FSM state encoding.
package spi_initiator_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SETUP = ST_SETUP,
    HIGH  = ST_HIGH,
    LOW   = ST_LOW,
    DONE  = ST_DONE
  } spi_init_state_t;

endpackage

// File: rtl/spi_initiator.sv
// SPI mode-0 initiator: shifts one BIT_WIDTH packet out on mosi while capturing miso.
// One packet in flight; the reply is held in DONE until recv_rdy, send_val is ignored while busy.
module spi_initiator
  import spi_initiator_pkg::*;
#(
  parameter int BIT_WIDTH = 20,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] send_msg,
  input  logic                 send_val,
  output logic                 send_rdy,
  output logic [BIT_WIDTH-1:0] recv_msg,
  output logic                 recv_parity,
  output logic                 recv_val,
  input  logic                 recv_rdy,
  output logic                 cs,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(BIT_WIDTH + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(BIT_WIDTH);

  spi_init_state_t      state_q, state_d;
  logic [CW-1:0]        half_q, half_d;
  logic [BW-1:0]        bits_q, bits_d;
  logic [BIT_WIDTH-1:0] tx_q, tx_d;
  logic [BIT_WIDTH-1:0] rx_q, rx_d;
  logic cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic val_q, val_d, par_q, par_d, rdy_q, rdy_d;
  logic half_done;

  assign half_done = (half_q == '0);

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bits_d  = bits_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    val_d   = val_q;
    par_d   = par_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      IDLE: begin
        if (send_val && rdy_q) begin
          tx_d    = send_msg;
          mosi_d  = send_msg[BIT_WIDTH-1];
          cs_d    = 1'b0;
          rdy_d   = 1'b0;
          half_d  = HALF_LOAD;
          bits_d  = '0;
          state_d = SETUP;
        end
      end
      SETUP, LOW: begin
        if (!half_done) begin
          half_d = half_q - CW'(1);
        end else if (state_q == LOW && bits_q == LAST_BIT) begin
          state_d = DONE;
          cs_d    = 1'b1;
          val_d   = 1'b1;
          par_d   = ^rx_q;
        end else begin
          // miso seen here is the value driven during the preceding low phase
          state_d = HIGH;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[BIT_WIDTH-2:0], miso};
          bits_d  = bits_q + BW'(1);
          half_d  = HALF_LOAD;
        end
      end
      HIGH: begin
        if (!half_done) begin
          half_d = half_q - CW'(1);
        end else begin
          state_d = LOW;
          sclk_d  = 1'b0;
          half_d  = HALF_LOAD;
          tx_d    = tx_q << 1;
          mosi_d  = (bits_q == LAST_BIT) ? 1'b0 : tx_q[BIT_WIDTH-2];
        end
      end
      DONE: begin
        if (recv_rdy) begin
          state_d = IDLE;
          val_d   = 1'b0;
          rdy_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      half_q  <= '0;
      bits_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      val_q   <= 1'b0;
      par_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bits_q  <= bits_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      val_q   <= val_d;
      par_q   <= par_d;
      rdy_q   <= rdy_d;
    end
  end

  assign send_rdy    = rdy_q;
  assign recv_msg    = rx_q;
  assign recv_parity = par_q;
  assign recv_val    = val_q;
  assign cs          = cs_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;

endmodule

// File: tb/tb_spi_initiator.sv
// Directed bench: two initiators (CLK_DIV=2 and CLK_DIV=1) against a behavioural mode-0 minion.
module tb_spi_initiator;

  logic clk = 1'b0;
  logic reset;
  logic [1:0][19:0] send_msg_w, rmsg_w;
  logic [1:0] send_val_w, send_rdy_w, rpar_w, rval_w, recv_rdy_w;
  logic [1:0] cs_w, sclk_w, mosi_w;
  logic [1:0] miso_w = 2'b00;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_initiator #(.BIT_WIDTH(20), .CLK_DIV(2)) dut0 (
    .clk(clk), .reset(reset),
    .send_msg(send_msg_w[0]), .send_val(send_val_w[0]), .send_rdy(send_rdy_w[0]),
    .recv_msg(rmsg_w[0]), .recv_parity(rpar_w[0]), .recv_val(rval_w[0]), .recv_rdy(recv_rdy_w[0]),
    .cs(cs_w[0]), .sclk(sclk_w[0]), .mosi(mosi_w[0]), .miso(miso_w[0])
  );

  spi_initiator #(.BIT_WIDTH(20), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset),
    .send_msg(send_msg_w[1]), .send_val(send_val_w[1]), .send_rdy(send_rdy_w[1]),
    .recv_msg(rmsg_w[1]), .recv_parity(rpar_w[1]), .recv_val(rval_w[1]), .recv_rdy(recv_rdy_w[1]),
    .cs(cs_w[1]), .sclk(sclk_w[1]), .mosi(mosi_w[1]), .miso(miso_w[1])
  );

  // Minion model: loads its reply on cs fall, captures mosi on sclk rise, shifts miso on sclk fall.
  logic [1:0][19:0] m_reply;
  logic [1:0][19:0] m_sh = '0;
  logic [1:0][19:0] m_cap = '0;
  logic [1:0] cs_prev = 2'b11;
  logic [1:0] sclk_prev = 2'b00;
  int  m_rises [2] = '{0, 0};
  time t_cs [2] = '{0, 0};
  time t_r0 [2] = '{0, 0};
  time t_r1 [2] = '{0, 0};

  always @(cs_w or sclk_w) begin
    for (int g = 0; g < 2; g++) begin
      if (cs_prev[g] === 1'b1 && cs_w[g] === 1'b0) begin
        m_sh[g]    = m_reply[g];
        miso_w[g]  = m_reply[g][19];
        m_cap[g]   = '0;
        m_rises[g] = 0;
        t_cs[g]    = $time;
      end else if (cs_w[g] === 1'b0) begin
        if (sclk_prev[g] === 1'b0 && sclk_w[g] === 1'b1) begin
          m_cap[g] = {m_cap[g][18:0], mosi_w[g]};
          if (m_rises[g] == 0) t_r0[g] = $time;
          else if (m_rises[g] == 1) t_r1[g] = $time;
          m_rises[g]++;
        end else if (sclk_prev[g] === 1'b1 && sclk_w[g] === 1'b0) begin
          m_sh[g]   = {m_sh[g][18:0], 1'b0};
          miso_w[g] = m_sh[g][19];
        end
      end
      cs_prev[g]   = cs_w[g];
      sclk_prev[g] = sclk_w[g];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves send_val high; returns one step after the accepting edge.
  task automatic start(input int u, input logic [19:0] msg, input logic [19:0] reply);
    int n;
    n = 0;
    m_reply[u]    = reply;
    send_msg_w[u] = msg;
    send_val_w[u] = 1'b1;
    do begin
      tick();
      n++;
    end while (cs_w[u] !== 1'b0 && n < 200);
    if (cs_w[u] !== 1'b0) check("accept_timeout", 32'(cs_w[u]), 32'd0);
  endtask

  // Counts cs-low cycles (accept cycle included) until cs rises.
  task automatic wait_done(input int u, output int lowc);
    lowc = 1;
    forever begin
      tick();
      if (cs_w[u] === 1'b1) break;
      lowc++;
      if (lowc > 500) begin
        check("done_timeout", 32'(cs_w[u]), 32'd1);
        break;
      end
    end
  endtask

  task automatic xfer(input int u, input logic [19:0] msg, input logic [19:0] reply,
                      output logic [19:0] got, output logic par, output int lowc);
    recv_rdy_w[u] = 1'b1;
    start(u, msg, reply);
    send_val_w[u] = 1'b0;
    wait_done(u, lowc);
    got = rmsg_w[u];
    par = rpar_w[u];
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] got, snap, v;
    logic par;
    int lowc, gap, seen, mism;

    reset = 1'b1;
    send_msg_w = '0;
    send_val_w = '0;
    recv_rdy_w = '0;
    m_reply = '0;

    // Reset values before any clock edge
    #2;
    check("rst_cs", 32'(cs_w[0]), 32'd1);
    check("rst_sclk", 32'(sclk_w[0]), 32'd0);
    check("rst_mosi", 32'(mosi_w[0]), 32'd0);
    check("rst_recv_val", 32'(rval_w[0]), 32'd0);
    check("rst_send_rdy", 32'(send_rdy_w[0]), 32'd1);
    check("rst_recv_msg", 32'(rmsg_w[0]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Basic transfer
    recv_rdy_w[0] = 1'b1;
    start(0, 20'hA5A5A, 20'h3C3C3);
    send_val_w[0] = 1'b0;
    wait_done(0, lowc);
    check("basic_cs_low", 32'(lowc), 32'd82);
    check("basic_recv_val", 32'(rval_w[0]), 32'd1);
    check("basic_recv_msg", 32'(rmsg_w[0]), 32'h3C3C3);
    check("basic_parity", 32'(rpar_w[0]), 32'd0);
    check("basic_mosi", 32'(m_cap[0]), 32'hA5A5A);
    check("basic_rises", 32'(m_rises[0]), 32'd20);
    check("basic_first_rise", 32'(t_r0[0] - t_cs[0]), 32'd20);
    check("basic_period", 32'(t_r1[0] - t_r0[0]), 32'd40);
    tick();
    check("basic_handshake_val", 32'(rval_w[0]), 32'd0);
    check("basic_handshake_rdy", 32'(send_rdy_w[0]), 32'd1);

    // Back-pressure with a dropped send_val pulse
    recv_rdy_w[0] = 1'b0;
    start(0, 20'h12345, 20'h0F0F0);
    send_val_w[0] = 1'b0;
    wait_done(0, lowc);
    snap = rmsg_w[0];
    check("bp_recv_msg", 32'(snap), 32'h0F0F0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        send_msg_w[0] = 20'h55555;
        send_val_w[0] = 1'b1;
      end
      tick();
      send_val_w[0] = 1'b0;
      check("bp_stable", 32'(rmsg_w[0]), 32'(snap));
      check("bp_send_rdy", 32'(send_rdy_w[0]), 32'd0);
      check("bp_cs", 32'(cs_w[0]), 32'd1);
      check("bp_sclk", 32'(sclk_w[0]), 32'd0);
    end
    check("bp_parity", 32'(rpar_w[0]), 32'd0);
    recv_rdy_w[0] = 1'b1;
    tick();
    check("bp_release_val", 32'(rval_w[0]), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cs_w[0] !== 1'b1) seen++;
    end
    check("bp_pulse_dropped", 32'(seen), 32'd0);

    // Back-to-back with send_val and recv_rdy held high
    recv_rdy_w[0] = 1'b1;
    start(0, 20'h00001, 20'h00001);
    send_msg_w[0] = 20'hFFFFE;
    m_reply[0] = 20'hFFFFE;
    wait_done(0, lowc);
    check("b2b_msg1", 32'(rmsg_w[0]), 32'h00001);
    check("b2b_par1", 32'(rpar_w[0]), 32'd1);
    check("b2b_mosi1", 32'(m_cap[0]), 32'h00001);
    gap = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cs_w[0] === 1'b0) break;
      gap++;
    end
    send_val_w[0] = 1'b0;
    check("b2b_gap", 32'(gap), 32'd2);
    wait_done(0, lowc);
    check("b2b_msg2", 32'(rmsg_w[0]), 32'hFFFFE);
    check("b2b_par2", 32'(rpar_w[0]), 32'd1);
    check("b2b_mosi2", 32'(m_cap[0]), 32'hFFFFE);
    tick();

    // Reset after the 7th sclk rise
    start(0, 20'hFFFFF, 20'hAAAAA);
    send_val_w[0] = 1'b0;
    seen = 0;
    while (m_rises[0] < 7 && seen < 200) begin
      tick();
      seen++;
    end
    check("mid_rises", 32'(m_rises[0]), 32'd7);
    #2 reset = 1'b1;
    #1;
    check("mid_cs", 32'(cs_w[0]), 32'd1);
    check("mid_sclk", 32'(sclk_w[0]), 32'd0);
    check("mid_mosi", 32'(mosi_w[0]), 32'd0);
    check("mid_send_rdy", 32'(send_rdy_w[0]), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rval_w[0] !== 1'b0) seen++;
    end
    check("mid_no_recv_val", 32'(seen), 32'd0);
    xfer(0, 20'h00007, 20'h00007, got, par, lowc);
    check("mid_echo_msg", 32'(got), 32'h00007);
    check("mid_echo_par", 32'(par), 32'd1);

    // CLK_DIV = 1
    xfer(1, 20'h3A5C1, 20'hC35A7, got, par, lowc);
    check("div1_cs_low", 32'(lowc), 32'd41);
    check("div1_period", 32'(t_r1[1] - t_r0[1]), 32'd20);
    check("div1_first_rise", 32'(t_r0[1] - t_cs[1]), 32'd10);
    check("div1_msg", 32'(got), 32'hC35A7);
    check("div1_mosi", 32'(m_cap[1]), 32'h3A5C1);
    mism = 0;
    for (int i = 0; i < 1000; i++) begin
      v = 20'($urandom);
      xfer(1, v, v, got, par, lowc);
      if (got !== v || par !== (^v) || lowc != 41 || m_cap[1] !== v) mism++;
    end
    check("div1_random_mismatches", 32'(mism), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
